// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and data width, common to TX and RX.
// No logic; types and constants only.
// Not applicable: no handshake lives here.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-rate clock enable: one-cycle tick every BAUD_DIV clk cycles, restartable by clr.
// Tick asserted while the count sits at BAUD_DIV-1; clr takes effect on the next edge.
// No backpressure: free-running counter.
module uart_baud_tick #(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    generate
        if (BAUD_DIV < 2) begin : g_bad_div
            $error("uart_baud_tick: BAUD_DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
// tx goes low one cycle after accept; frame = (10+PARITY_EN+STOP_BITS-1)*BAUD_DIV cycles.
// tx_ready only in IDLE; tx_valid during a frame is held off until the tx_done cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRQ   = 100,
    parameter int BAUD_RATE = 10,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int BAUD_DIV = CLK_FRQ / BAUD_RATE;
    localparam int BIT_W    = $clog2(DATA_W);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t       state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              stop_cnt, stop_cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par, par_nxt;
    logic              tx_nxt;
    logic              done_nxt;
    logic              accept;
    logic              tick;

    assign accept   = tx_valid && (state == IDLE);
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            shift    <= shift_nxt;
            par      <= par_nxt;
            tx       <= tx_nxt;
            tx_done  <= done_nxt;
        end
    end

    // tx is driven from the next-state decode so each bit lands on the line at its boundary edge.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        shift_nxt    = shift;
        par_nxt      = par;
        tx_nxt       = tx;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt    = START;
                    shift_nxt    = tx_data;
                    par_nxt      = ^tx_data;
                    bit_cnt_nxt  = '0;
                    stop_cnt_nxt = 1'b0;
                    tx_nxt       = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                    shift_nxt = {1'b0, shift[DATA_W-1:1]};
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        stop_cnt_nxt = 1'b0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        tx_nxt      = shift[0];
                        shift_nxt   = {1'b0, shift[DATA_W-1:1]};
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt    = STOP;
                    stop_cnt_nxt = 1'b0;
                    tx_nxt       = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    tx_nxt = 1'b1;
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one default instance and one with even parity and two stop bits.
module tb_uart_tx;

    localparam int BD = 10;

    logic       clk;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int n_vec;
    int n_bad;

    uart_tx #(
        .CLK_FRQ   (100),
        .BAUD_RATE (10),
        .PARITY_EN (0),
        .STOP_BITS (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (data_a),
        .tx_valid (valid_a),
        .tx_ready (ready_a),
        .tx       (tx_a),
        .tx_busy  (busy_a),
        .tx_done  (done_a)
    );

    uart_tx #(
        .CLK_FRQ   (100),
        .BAUD_RATE (10),
        .PARITY_EN (1),
        .STOP_BITS (2)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (data_b),
        .tx_valid (valid_b),
        .tx_ready (ready_b),
        .tx       (tx_b),
        .tx_busy  (busy_b),
        .tx_done  (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Call just after the accept edge; returns at the negedge of the tx_done cycle.
    task automatic check_frame(input logic sel, input logic [7:0] d, input int nbits,
                               input logic [11:0] exp, input string tag);
        int         len;
        int         bit_err;
        int         hs_err;
        logic [7:0] rx;
        logic       par_s;
        logic       t;
        logic [2:0] hs;
        len     = nbits * BD;
        bit_err = 0;
        hs_err  = 0;
        rx      = '0;
        par_s   = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            t  = sel ? tx_b : tx_a;
            hs = sel ? {busy_b, ready_b, done_b} : {busy_a, ready_a, done_a};
            if (t !== exp[i / BD]) bit_err++;
            if (hs !== 3'b100) hs_err++;
            if (i % BD == BD / 2) begin
                if (i / BD >= 1 && i / BD <= 8) rx[i / BD - 1] = t;
                if (i / BD == 9) par_s = t;
            end
        end
        chk({tag, " bit errors"}, bit_err, 0);
        chk({tag, " busy/ready errors"}, hs_err, 0);
        chk({tag, " rx byte"}, {24'd0, rx}, {24'd0, d});
        if (sel) chk({tag, " parity odd"}, {31'd0, ^{rx, par_s}}, 0);
        @(negedge clk);
        if (sel) chk({tag, " done cycle tx/busy/ready/done"}, {28'd0, tx_b, busy_b, ready_b, done_b}, 32'b1011);
        else     chk({tag, " done cycle tx/busy/ready/done"}, {28'd0, tx_a, busy_a, ready_a, done_a}, 32'b1011);
    endtask

    initial begin
        int bad;
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        valid_a = 1'b0;
        valid_b = 1'b0;

        // frames listed as {stop(s), [parity], data[7:0], start}; bit 0 goes out first
        vecs[0] = '{1'b0, 8'hA5, 10, 12'b00_1_10100101_0};
        vecs[1] = '{1'b0, 8'h00, 10, 12'b00_1_00000000_0};
        vecs[2] = '{1'b0, 8'hFF, 10, 12'b00_1_11111111_0};
        vecs[3] = '{1'b0, 8'h3C, 10, 12'b00_1_00111100_0};
        vecs[4] = '{1'b1, 8'h07, 12, 12'b1_1_1_00000111_0};
        vecs[5] = '{1'b1, 8'h81, 12, 12'b1_1_0_10000001_0};
        vecs[6] = '{1'b1, 8'h00, 12, 12'b1_1_0_00000000_0};
        vecs[7] = '{1'b1, 8'hFE, 12, 12'b1_1_1_11111110_0};

        // reset state
        #12;
        chk("reset a tx/busy/done", {29'd0, tx_a, busy_a, done_a}, 32'b100);
        chk("reset b tx/busy/done", {29'd0, tx_b, busy_b, done_b}, 32'b100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready a after reset", {31'd0, ready_a}, 1);
        chk("ready b after reset", {31'd0, ready_b}, 1);

        // table of single frames; input data is scrambled after accept
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            if (vecs[v].sel) begin
                data_b  = vecs[v].data;
                valid_b = 1'b1;
            end else begin
                data_a  = vecs[v].data;
                valid_a = 1'b1;
            end
            @(posedge clk);
            #1;
            valid_a = 1'b0;
            valid_b = 1'b0;
            data_a  = ~data_a;
            data_b  = ~data_b;
            check_frame(vecs[v].sel, vecs[v].data, vecs[v].nbits, vecs[v].exp,
                        $sformatf("vec%0d", v));
            @(negedge clk);
            if (vecs[v].sel) chk($sformatf("vec%0d done drops", v), {30'd0, busy_b, done_b}, 0);
            else             chk($sformatf("vec%0d done drops", v), {30'd0, busy_a, done_a}, 0);
        end

        // back-to-back with tx_valid held high
        @(negedge clk);
        data_a  = 8'h55;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        data_a = 8'hAA;
        check_frame(1'b0, 8'h55, 10, 12'b00_1_01010101_0, "b2b first");
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        check_frame(1'b0, 8'hAA, 10, 12'b00_1_10101010_0, "b2b second");

        // data change and valid pulse mid-frame must be ignored
        @(negedge clk);
        data_a  = 8'hC3;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        fork
            check_frame(1'b0, 8'hC3, 10, 12'b00_1_11000011_0, "midframe valid");
            begin
                repeat (35) @(posedge clk);
                #1;
                data_a  = 8'h00;
                valid_a = 1'b1;
                @(posedge clk);
                #1;
                valid_a = 1'b0;
            end
        join
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        chk("midframe pulse not accepted", bad, 0);

        // asynchronous reset during data bit 3
        @(negedge clk);
        data_a  = 8'hA5;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        repeat (45) @(negedge clk);
        chk("bit3 low before reset", {31'd0, tx_a}, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset tx/busy/done", {29'd0, tx_a, busy_a, done_a}, 32'b100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after mid-frame reset", {31'd0, ready_a}, 1);
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        chk("no done after abort", bad, 0);
        @(negedge clk);
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        check_frame(1'b0, 8'h3C, 10, 12'b00_1_00111100_0, "post-reset frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
